// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode-side inputs, forwarding taps and EX-side outputs of the ID/EX operand stage.
// master drives the ID/forwarding side; slave is the pipeline register itself.
interface id_ex_operand_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [5:0]        id_op;
    logic [4:0]        id_shamt;
    logic [3:0]        id_ctrl;
    logic              flush;
    logic              ex_mem_reg_write;
    logic [REG_AW-1:0] ex_mem_rd;
    logic [DATA_W-1:0] ex_mem_result;
    logic              mem_wb_reg_write;
    logic [REG_AW-1:0] mem_wb_rd;
    logic [DATA_W-1:0] mem_wb_data;
    logic              stall;
    logic [DATA_W-1:0] ex_source1;
    logic [DATA_W-1:0] ex_source2;
    logic [5:0]        ex_operation;
    logic [4:0]        ex_shamt;
    logic [REG_AW-1:0] ex_rd;
    logic [3:0]        ex_ctrl;

    modport master (
        output id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_op, id_shamt, id_ctrl, flush,
        output ex_mem_reg_write, ex_mem_rd, ex_mem_result,
        output mem_wb_reg_write, mem_wb_rd, mem_wb_data,
        input  stall, ex_source1, ex_source2, ex_operation, ex_shamt, ex_rd, ex_ctrl
    );

    modport slave (
        input  id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_op, id_shamt, id_ctrl, flush,
        input  ex_mem_reg_write, ex_mem_rd, ex_mem_result,
        input  mem_wb_reg_write, mem_wb_rd, mem_wb_data,
        output stall, ex_source1, ex_source2, ex_operation, ex_shamt, ex_rd, ex_ctrl
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and hazard stall.
// Define ID_EX_FORWARD_EN for forwarding + load-use stall; otherwise no forwarding, stall on any RAW.
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [5:0]        r_op;
    logic [4:0]        r_shamt;
    logic [3:0]        r_ctrl;

    logic              w_stall;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;

`ifdef ID_EX_FORWARD_EN
    logic w_ld_hit_rs;
    logic w_ld_hit_rt;

    assign w_ld_hit_rs = (r_rd == bus.id_rs);
    assign w_ld_hit_rt = (r_rd == bus.id_rt);
    assign w_stall     = r_ctrl[2] && (r_rd != '0) && (w_ld_hit_rs || w_ld_hit_rt);

    // EX/MEM holds the newer value, so it is tested first; register 0 is never forwarded.
    always_comb begin
        w_src1 = r_rs_data;
        if (bus.ex_mem_reg_write && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == r_rs)) begin
            w_src1 = bus.ex_mem_result;
        end else if (bus.mem_wb_reg_write && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == r_rs)) begin
            w_src1 = bus.mem_wb_data;
        end
    end

    always_comb begin
        w_src2 = r_rt_data;
        if (bus.ex_mem_reg_write && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == r_rt)) begin
            w_src2 = bus.ex_mem_result;
        end else if (bus.mem_wb_reg_write && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == r_rt)) begin
            w_src2 = bus.mem_wb_data;
        end
    end
`else
    logic w_raw_rs;
    logic w_raw_rt;
    logic w_unused_fwd;

    // Without forwarding, any in-flight writer of a source register must drain first.
    assign w_raw_rs = (bus.id_rs != '0) &&
                      ((r_ctrl[3] && (r_rd == bus.id_rs)) ||
                       (bus.ex_mem_reg_write && (bus.ex_mem_rd == bus.id_rs)));
    assign w_raw_rt = (bus.id_rt != '0) &&
                      ((r_ctrl[3] && (r_rd == bus.id_rt)) ||
                       (bus.ex_mem_reg_write && (bus.ex_mem_rd == bus.id_rt)));
    assign w_stall  = w_raw_rs || w_raw_rt;

    assign w_src1 = r_rs_data;
    assign w_src2 = r_rt_data;

    assign w_unused_fwd = ^{bus.ex_mem_result, bus.mem_wb_reg_write, bus.mem_wb_rd,
                            bus.mem_wb_data, r_rs, r_rt};
`endif

    always_ff @(posedge clk) begin
        if (rst || bus.flush || w_stall) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_op      <= '0;
            r_shamt   <= '0;
            r_ctrl    <= '0;
        end else begin
            r_rs_data <= bus.id_rs_data;
            r_rt_data <= bus.id_rt_data;
            r_rs      <= bus.id_rs;
            r_rt      <= bus.id_rt;
            r_rd      <= bus.id_rd;
            r_op      <= bus.id_op;
            r_shamt   <= bus.id_shamt;
            r_ctrl    <= bus.id_ctrl;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.ex_source1   = w_src1;
    assign bus.ex_source2   = w_src2;
    assign bus.ex_operation = r_op;
    assign bus.ex_shamt     = r_shamt;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_ctrl      = r_ctrl;
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU.
- Captures decoded operands, function code, shamt and control bits from the decode stage on each clock.
- Drives the ALU Source1/Source2/operation/shamt inputs, with EX/MEM and MEM/WB forwarding applied.
- Detects load-use hazards and raises a stall to the front end; a stalled or flushed slot becomes a bubble.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- id_rs_data  input  DATA_W  register-file read data for rs
- id_rt_data  input  DATA_W  register-file read data for rt
- id_rs  input  REG_AW  rs address
- id_rt  input  REG_AW  rt address
- id_rd  input  REG_AW  destination address
- id_op  input  6  ALU function code (27..33 valid)
- id_shamt  input  5  shift amount
- id_ctrl  input  4  [3] reg_write, [2] mem_read, [1] mem_write, [0] mem_to_reg
- flush  input  1  replace the incoming instruction with a bubble
- ex_mem_reg_write  input  1  EX/MEM instruction writes the register file
- ex_mem_rd  input  REG_AW  EX/MEM destination
- ex_mem_result  input  DATA_W  EX/MEM ALU result
- mem_wb_reg_write  input  1  MEM/WB instruction writes the register file
- mem_wb_rd  input  REG_AW  MEM/WB destination
- mem_wb_data  input  DATA_W  MEM/WB writeback data
- stall  output  1  hazard stall request to PC and IF/ID (combinational)
- ex_source1  output  DATA_W  ALU Source1 (forwarded)
- ex_source2  output  DATA_W  ALU Source2 (forwarded); also the store data
- ex_operation  output  6  ALU operation (registered)
- ex_shamt  output  5  ALU shamt (registered)
- ex_rd  output  REG_AW  destination (registered)
- ex_ctrl  output  4  control bits (registered, same layout as id_ctrl)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Register contents: rs_data_q, rt_data_q, rs_q, rt_q, ex_rd, ex_operation, ex_shamt, ex_ctrl.
- Reset: every register cleared to 0. After reset, ex_operation=0, ex_ctrl=0, ex_rd=0, ex_shamt=0, ex_source1=ex_source2=0, stall=0.
- Update priority at each rising edge: rst > flush > stall > normal load.
- Bubble: all registers loaded with 0. Op 0 makes the ALU hold its result; ctrl 0 means no write and no memory access.
- flush=1: load a bubble. flush and stall together also load a bubble.
- Load-use stall: stall = ex_ctrl[2] && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt).
  - While stall=1, load a bubble; the front end holds the ID instruction.
  - stall deasserts the next cycle, once the bubble occupies EX.
- Latency: 1 cycle from ID inputs to ex_* outputs. Forwarding is combinational from the registered fields to ex_source1/2 in the same cycle.
- Forwarding for Source1 (operand rs_q):
  - if ex_mem_reg_write && ex_mem_rd!=0 && ex_mem_rd==rs_q, use ex_mem_result;
  - else if mem_wb_reg_write && mem_wb_rd!=0 && mem_wb_rd==rs_q, use mem_wb_data;
  - else use rs_data_q.
- Forwarding for Source2: same rules using rt_q and rt_data_q.
- Priority: EX/MEM beats MEM/WB (newest value). Register 0 is never forwarded; it reads as the stored value.
- Distance-3 hazards: resolved by the register file (write-before-read), not by this block.
- id_op values outside 27..33 pass through unchanged.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding and load-use stall exactly as specified above.
- Undefined:
  - No forwarding: ex_source1=rs_data_q, ex_source2=rt_data_q.
  - stall asserts on any RAW hazard where id_rs or id_rt (nonzero) matches either of:
    - ex_rd with ex_ctrl[3]=1;
    - ex_mem_rd with ex_mem_reg_write=1.
  - Stalled cycles insert bubbles, with the same priority order as above.

Test Plan:
- rst=1 for 2 cycles with random ID inputs -> all ex_* outputs 0 and stall=0 in the cycle after each reset edge.
- Load id_rs_data=5, id_rt_data=7, op=27, ctrl=4'b1000, rd=3 -> next cycle ex_source1=5, ex_source2=7, ex_operation=27, ex_rd=3.
- EX holds rs_q=3, with ex_mem_rd=3/ex_mem_result=0x11 and mem_wb_rd=3/mem_wb_data=0x22, both writing -> ex_source1=0x11. Drop ex_mem_reg_write -> ex_source1=0x22.
- EX holds a load (ctrl=4'b1101, rd=4) and ID presents id_rt=4 -> stall=1. Next cycle ex_ctrl=0, ex_operation=0, stall=0.
- Forwarding targets rd=0 with ex_mem_result=0xFF -> ex_source1 equals rs_data_q (0), not 0xFF.
- flush=1 and rst=0 with a valid ID instruction -> next cycle bubble. rst=1 with flush=1 -> reset values.
